// File: rtl/hall_emu_pkg.sv
// Hall sensor emulator shared types, code table and helpers.
// Fault option macro: HALL_EMU_FAULT_INJ_EN.
package hall_emu_pkg;

   typedef logic [2:0] sector_t;

   localparam sector_t LAST_SECTOR = 3'd5;

   localparam logic [2:0] HALL_RESET_CODE = 3'b011;
   localparam logic [2:0] HALL_FAULT_CODE = 3'b000;

   // Entry [n] is the code of sector n; [0] is 011.
   localparam logic [5:0][2:0] HALL_TABLE = {
      3'b010, 3'b110, 3'b100,
      3'b101, 3'b001, 3'b011
   };

   function automatic sector_t next_sector(
      input sector_t s,
      input logic    fwd
   );
      sector_t n;
      if (fwd) begin
         n = (s >= LAST_SECTOR) ? 3'd0 : s + 3'd1;
      end else begin
         n = (s == 3'd0 || s > LAST_SECTOR) ?
             LAST_SECTOR : s - 3'd1;
      end
      return n;
   endfunction

   function automatic logic [2:0] hall_code(
      input sector_t s
   );
      return (s > LAST_SECTOR) ?
             HALL_RESET_CODE : HALL_TABLE[s];
   endfunction

endpackage

// File: rtl/hall_step_timer.sv
// Step period timer: shadow/active period and step counter.
// Emits a boundary strobe on the last cycle of each step.
module hall_step_timer
   import hall_emu_pkg::*;
#(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   input  logic             period_load,
   output logic             boundary
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0] active_q, active_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             running;

   // Period hand-over and counting; steps are never truncated.
   always_comb begin
      running  = (active_q != '0);
      boundary = en && running &&
                 (cnt_q == active_q - CNT_ONE);
      shadow_d = period_load ? period : shadow_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      if (!running) begin
         active_d = shadow_q;
         cnt_d    = '0;
      end else if (boundary) begin
         active_d = period_load ? period : shadow_q;
         cnt_d    = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Timer state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
         cnt_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/hall_sensor_emulator.sv
// Hall commutation code generator for HIL bring-up.
// Optional invalid-code injection: HALL_EMU_FAULT_INJ_EN.
module hall_sensor_emulator
   import hall_emu_pkg::*;
#(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             dir,
   input  logic [CNT_W-1:0] period,
   input  logic             period_load,
`ifdef HALL_EMU_FAULT_INJ_EN
   input  logic             fault_inj,
   output logic             fault_active,
`endif
   output logic [2:0]       HALL,
   output logic [2:0]       sector,
   output logic             step_pulse,
   output logic             rev_pulse
);

   logic       boundary;
   sector_t    sector_q, sector_d;
   logic [2:0] hall_q, hall_d;
   logic       step_q, step_d;
   logic       rev_q, rev_d;
`ifdef HALL_EMU_FAULT_INJ_EN
   logic       fault_q, fault_d;
`endif

   hall_step_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .period     (period),
      .period_load(period_load),
      .boundary   (boundary)
   );

   // Sector advance, code lookup, pulses and fault mux.
   always_comb begin
      sector_d = sector_q;
      step_d   = 1'b0;
      rev_d    = 1'b0;
      if (boundary) begin
         sector_d = next_sector(sector_q, dir);
         step_d   = 1'b1;
         rev_d    = dir ? (sector_q == LAST_SECTOR)
                        : (sector_q == 3'd0);
      end
      hall_d = hall_code(sector_d);
`ifdef HALL_EMU_FAULT_INJ_EN
      fault_d = fault_inj;
      if (fault_inj) begin
         hall_d = HALL_FAULT_CODE;
      end
`endif
   end

   // Output and sector registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sector_q <= 3'd0;
         hall_q   <= HALL_RESET_CODE;
         step_q   <= 1'b0;
         rev_q    <= 1'b0;
`ifdef HALL_EMU_FAULT_INJ_EN
         fault_q  <= 1'b0;
`endif
      end else begin
         sector_q <= sector_d;
         hall_q   <= hall_d;
         step_q   <= step_d;
         rev_q    <= rev_d;
`ifdef HALL_EMU_FAULT_INJ_EN
         fault_q  <= fault_d;
`endif
      end
   end

   assign HALL       = hall_q;
   assign sector     = sector_q;
   assign step_pulse = step_q;
   assign rev_pulse  = rev_q;
`ifdef HALL_EMU_FAULT_INJ_EN
   assign fault_active = fault_q;
`endif

endmodule

// File: tb/tb_hall_sensor_emulator.sv
// Directed bench for hall_sensor_emulator.
// Expected steps are queued up front and matched on step_pulse.
module tb_hall_sensor_emulator;

   localparam int CNT_W = 24;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             dir;
   logic [CNT_W-1:0] period;
   logic             period_load;
   logic [2:0]       hall;
   logic [2:0]       sector;
   logic             step_pulse;
   logic             rev_pulse;
`ifdef HALL_EMU_FAULT_INJ_EN
   logic             fault_inj;
   logic             fault_active;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   hall_sensor_emulator #(
      .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .dir        (dir),
      .period     (period),
      .period_load(period_load),
`ifdef HALL_EMU_FAULT_INJ_EN
      .fault_inj   (fault_inj),
      .fault_active(fault_active),
`endif
      .HALL       (hall),
      .sector     (sector),
      .step_pulse (step_pulse),
      .rev_pulse  (rev_pulse)
   );

   typedef struct {
      logic [2:0] hall;
      logic [2:0] sec;
      logic       rev;
      int         at;
   } step_t;

   step_t q[$];

   logic [2:0] code_tb [6] = '{
      3'b011, 3'b001, 3'b101,
      3'b100, 3'b110, 3'b010
   };

   int tests = 0;
   int fails = 0;
   int exp_sec = 0;
   int last_cyc = 0;
   bit mon_on = 1'b0;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, got, exp);
      end
   endtask

   // One cycle; match any step strobe against the queue.
   task automatic tick();
      step_t e;
      @(negedge clk);
      if (mon_on) begin
         if (step_pulse === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_step", cyc, 32'hffff_ffff);
            end else begin
               e = q.pop_front();
               chk("step_cycle", cyc, e.at);
               chk("step_hall", hall, e.hall);
               chk("step_sector", sector, e.sec);
               chk("step_rev", rev_pulse, e.rev);
            end
         end else begin
            chk("rev_idle", rev_pulse, 0);
         end
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick();
   endtask

   task automatic expect_steps(
      input int n,
      input bit d,
      input int p
   );
      int old;
      for (int i = 0; i < n; i++) begin
         old = exp_sec;
         if (d) exp_sec = (old == 5) ? 0 : old + 1;
         else   exp_sec = (old == 0) ? 5 : old - 1;
         last_cyc += p;
         q.push_back('{hall: code_tb[exp_sec],
                       sec:  3'(exp_sec),
                       rev:  d ? (old == 5) : (old == 0),
                       at:   last_cyc});
      end
   endtask

   int c0, mark, mark2, s, b, t2;

   initial begin
      rst_n       = 1'b0;
      en          = 1'b0;
      dir         = 1'b1;
      period      = '0;
      period_load = 1'b0;
`ifdef HALL_EMU_FAULT_INJ_EN
      fault_inj   = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_hall", hall, 3'b011);
      chk("rst_sector", sector, 0);
      chk("rst_step", step_pulse, 0);
      chk("rst_rev", rev_pulse, 0);
`ifdef HALL_EMU_FAULT_INJ_EN
      chk("rst_fault", fault_active, 0);
`endif
      rst_n = 1'b1;
      tick();
      mon_on = 1'b1;

      // Forward run at P=4 from stopped: two revolutions.
      c0          = cyc;
      en          = 1'b1;
      period      = 24'd4;
      period_load = 1'b1;
      last_cyc    = c0 + 2;
      expect_steps(12, 1'b1, 4);
      tick();
      period_load = 1'b0;

      // Reverse in sector 2: 001, 011, 010.
      expect_steps(2, 1'b1, 4);
      mark = last_cyc;
      expect_steps(3, 1'b0, 4);
      wait_cyc(mark + 1);
      dir = 1'b0;

      // Period 8 then 3 mid-step, then 5 at a boundary.
      mark2 = last_cyc;
      expect_steps(1, 1'b0, 4);
      expect_steps(1, 1'b0, 8);
      s = last_cyc;
      expect_steps(1, 1'b0, 8);
      expect_steps(4, 1'b0, 3);
      b = last_cyc;
      expect_steps(1, 1'b0, 15);
      expect_steps(2, 1'b0, 5);
      t2 = last_cyc;

      wait_cyc(mark2 + 1);
      period      = 24'd8;
      period_load = 1'b1;
      tick();
      period_load = 1'b0;
      wait_cyc(s + 1);
      period      = 24'd3;
      period_load = 1'b1;
      tick();
      period_load = 1'b0;
      wait_cyc(b - 1);
      period      = 24'd5;
      period_load = 1'b1;
      tick();
      period_load = 1'b0;

      // Enable dropped for 10 cycles at cnt 2 of P=5.
      wait_cyc(b + 2);
      en = 1'b0;
      wait_cyc(b + 8);
      chk("hold_hall", hall, code_tb[4]);
      chk("hold_step", step_pulse, 0);
      wait_cyc(b + 12);
      en = 1'b1;
      wait_cyc(t2 + 1);
      chk("queue_drained", q.size(), 0);

      // One-cycle reset mid-revolution.
      wait_cyc(t2 + 2);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_hall", hall, 3'b011);
      chk("mid_rst_sector", sector, 0);
      chk("mid_rst_step", step_pulse, 0);
      chk("mid_rst_rev", rev_pulse, 0);
      rst_n = 1'b1;
      repeat (20) tick();
      chk("post_rst_hall", hall, 3'b011);
      chk("post_rst_sector", sector, 0);

`ifdef HALL_EMU_FAULT_INJ_EN
      // Fault held 6 cycles across a step at P=4.
      mon_on      = 1'b0;
      dir         = 1'b1;
      c0          = cyc;
      period      = 24'd4;
      period_load = 1'b1;
      tick();
      period_load = 1'b0;
      wait_cyc(c0 + 6);
      chk("pre_fault_hall", hall, 3'b001);
      fault_inj = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("fault_hall", hall, 3'b000);
         chk("fault_flag", fault_active, 1);
      end
      fault_inj = 1'b0;
      tick();
      chk("release_hall", hall, 3'b101);
      chk("release_flag", fault_active, 0);
      chk("release_sector", sector, 2);
`endif

      tick();
      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
   end

endmodule

// File: doc/hall_sensor_emulator.md
# hall_sensor_emulator

- Generates the 3-bit Hall commutation code that the SPWM `Control_block` consumes on its `HALL` input.
- Replaces the physical BLDC Hall sensors for on-FPGA hardware-in-the-loop bring-up of the commutation/SPWM path.
- Steps through the 6-state electrical sequence at a programmable rate, in either direction.
- Emits per-step and per-electrical-revolution strobes for speed-loop and encoder cross-checks.

## Interface
Parameters:
- `CNT_W`, 24: width of the step-period counter and period input.

Ports:
- `clk`  in  1: single system clock.
- `rst_n`  in  1: reset, synchronous and active-low.
- `en`  in  1: run enable. Low freezes the counter and holds `HALL`.
- `dir`  in  1: 1 = forward, 0 = reverse. Sampled only at step boundaries.
- `period`  in  CNT_W: clock cycles per Hall step. 0 = stopped.
- `period_load`  in  1: one-cycle strobe that captures `period` into the shadow register.
- `HALL`  out  3: registered Hall code.
- `sector`  out  3: current sector index, 0..5.
- `step_pulse`  out  1: one-cycle strobe on every `HALL` change.
- `rev_pulse`  out  1: one-cycle strobe on electrical-revolution wrap.

## Operation
Forward sequence, sector 0..5: 011, 001, 101, 100, 110, 010, then wraps to sector 0.
- Reverse traverses the same table in descending sector order: 0 → 5 → 4 …
- Codes 000 and 111 are never produced, except under the fault option (see Configuration).

Reset values:
- `HALL` = 3'b011; `sector` = 0.
- `step_pulse` = 0; `rev_pulse` = 0.
- Counter = 0; active period = 0; shadow period = 0.

Registers: shadow period, active period, counter `cnt` (0..active−1), `sector`.

Period handling:
- `period_load` writes the shadow register.
- If the active period is 0 (stopped), the shadow transfers to active on the next edge and `cnt` is cleared.
- If the active period is nonzero, the shadow transfers only at a step boundary, so no step is ever truncated.
- A `period_load` in the same cycle as a boundary: the new value bypasses the shadow and governs the step that starts at that boundary.
- Loading 0: the emulator stops after completing the current step; `HALL` holds.

Step boundary condition: `en` = 1, active period ≠ 0, and `cnt` == active−1. On that edge:
- `sector` advances by ±1 mod 6 according to the `dir` value sampled then.
- `HALL` takes the table code of the new sector.
- `cnt` is cleared.
- `step_pulse` = 1 for exactly one cycle.
- `rev_pulse` = 1 on forward 5→0 or reverse 0→5, coincident with `step_pulse`.

Other rules:
- `en` low: `cnt`, `sector` and `HALL` are frozen and both pulses are 0. Counting resumes from the frozen `cnt`.
- A `dir` change mid-step has no effect until the next boundary. Reversal produces the immediately previous code (e.g. 101 → 001).
- Reset mid-operation: every register returns to its reset value on the next edge, regardless of state.

## Timing
- Outputs are fully registered; there is no combinational path from inputs to outputs.
- With active period P, `HALL` changes every P cycles while `en` = 1. One electrical revolution = 6P cycles.
- From stopped: a `period_load` of P at edge k makes P active at edge k+1. The first `HALL` change is at edge k+1+P.
- `step_pulse` and `rev_pulse` are asserted in the same cycle the new `HALL` value appears.
- P = 1 is legal: `HALL` changes every cycle and `step_pulse` stays high continuously.

## Configuration
Macro: `HALL_EMU_FAULT_INJ_EN`.
- Defined:
  - Adds input `fault_inj` (1 bit) and output `fault_active` (1 bit).
  - While `fault_inj` = 1, registered `HALL` = 3'b000 (invalid code) and `fault_active` = 1.
  - `cnt` and `sector` keep running normally underneath.
  - On release, `HALL` shows the current sector's code on the next edge.
- Not defined: neither port exists and `HALL` is always a valid code.

## Structure
- Package `hall_emu_pkg` holds:
  - the 6-entry Hall code constant table;
  - the `sector_t` 3-bit typedef;
  - a next-sector function taking sector and direction;
  - the `HALL_RESET_CODE` constant.
- Sub-module `hall_step_timer`: contains the shadow/active period registers and `cnt`, and outputs a boundary strobe.
- The top level contains the sector register, the code lookup, the pulses and the fault mux.

## Test plan
- Reset, then load P = 4, `en` = 1, `dir` = 1 → `HALL` goes 011 → 001 at 5 cycles after the load edge, then changes every 4 cycles; `rev_pulse` fires once every 24 cycles, coincident with 010 → 011.
- `dir` toggled to 0 mid-step while in sector 2 (101) → at the next boundary `HALL` = 001, then 011, then 010.
- P = 8 running; load P = 3 at cycle 2 of a step → current step still lasts 8 cycles, following steps last 3.
- `en` dropped for 10 cycles with `cnt` = 2 of P = 5 → `HALL` is held, no pulses; the next change occurs 3 cycles after `en` returns.
- `rst_n` = 0 for 1 cycle mid-revolution → `HALL` = 011, `sector` = 0, pulses 0; `HALL` stays static until a new `period_load`.
- With `HALL_EMU_FAULT_INJ_EN` defined: `fault_inj` held for 6 cycles at P = 4 → `HALL` = 000 throughout; after release `HALL` shows the code of the sector that advanced underneath.
